// File: rtl/led_pio_sequencer.sv
// Plays a CPU-loaded table of up to 8 LED patterns into the LED PIO at a programmable period, once or looping.
// Control reads are zero-latency; the first strobe follows a run write by 1 cycle. The PIO is a write-only target with no backpressure.
module led_pio_sequencer #(
    parameter int LED_W    = 8,
    parameter int PERIOD_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ctl_chipselect,
    input  logic        ctl_write_n,
    input  logic [3:0]  ctl_address,
    input  logic [31:0] ctl_writedata,
    output logic [31:0] ctl_readdata,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [1:0]  pio_address,
    output logic [31:0] pio_writedata,
    output logic        irq
);

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT} state_t;

    state_t                state, state_nxt;
    logic                  run, loop, irq_en, done;
    logic [2:0]            index;
    logic [2:0]            last;
    logic [PERIOD_W-1:0]   period;
    logic [PERIOD_W-1:0]   wait_cnt;
    logic [LED_W-1:0]      pattern [8];

    logic                  ctl_wr;
    logic                  wr_control, wr_status, wr_period, wr_last, wr_pattern;
    logic [PERIOD_W-1:0]   p_eff;
    logic                  at_last;
    logic                  seq_end;
    logic                  busy;
    logic                  ctl_unused;

    assign ctl_wr     = ctl_chipselect & ~ctl_write_n;
    assign wr_control = ctl_wr && (ctl_address == 4'd0);
    assign wr_status  = ctl_wr && (ctl_address == 4'd1);
    assign wr_period  = ctl_wr && (ctl_address == 4'd2);
    assign wr_last    = ctl_wr && (ctl_address == 4'd3);
    assign wr_pattern = ctl_wr && ctl_address[3];
    assign ctl_unused = &{1'b0, ctl_writedata};

    assign p_eff   = (period == '0) ? PERIOD_W'(1) : period;
    // >= rather than == so a LAST lowered below the current index mid-run still ends the pass
    assign at_last = (index >= last);
    assign seq_end = at_last && !loop;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (wr_control && ctl_writedata[0]) state_nxt = S_STROBE;
            end
            S_STROBE: begin
                if (wr_control)                 state_nxt = ctl_writedata[0] ? S_STROBE : S_IDLE;
                else if (seq_end)               state_nxt = S_IDLE;
                else if (p_eff == PERIOD_W'(1)) state_nxt = S_STROBE;
                else                            state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (wr_control)          state_nxt = ctl_writedata[0] ? S_STROBE : S_IDLE;
                else if (wait_cnt == '0) state_nxt = S_STROBE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_writedata  = '0;
        if (state == S_STROBE) begin
            pio_chipselect             = 1'b1;
            pio_write_n                = 1'b0;
            pio_writedata[LED_W-1:0]   = pattern[index];
        end
    end

    assign pio_address = 2'b00;
    assign irq         = done & irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run      <= 1'b0;
            loop     <= 1'b0;
            irq_en   <= 1'b0;
            done     <= 1'b0;
            index    <= '0;
            last     <= '0;
            period   <= '0;
            wait_cnt <= '0;
            for (int i = 0; i < 8; i++) pattern[i] <= '0;
        end else begin
            if (wr_period)  period <= ctl_writedata[PERIOD_W-1:0];
            if (wr_last)    last   <= ctl_writedata[2:0];
            if (wr_pattern) pattern[ctl_address[2:0]] <= ctl_writedata[LED_W-1:0];

            // A CONTROL write overrides the strobe's own index/run update, including abort
            if (wr_control) begin
                run    <= ctl_writedata[0];
                loop   <= ctl_writedata[1];
                irq_en <= ctl_writedata[2];
                if (ctl_writedata[0]) begin
                    index <= '0;
                    done  <= 1'b0;
                end
            end else if (state == S_STROBE) begin
                if (!at_last) begin
                    index <= index + 3'd1;
                end else if (loop) begin
                    index <= '0;
                end else begin
                    done <= 1'b1;
                    run  <= 1'b0;
                end
            end

            // Completion set beats a simultaneous write-1-clear
            if (wr_status && ctl_writedata[1] && !(state == S_STROBE && !wr_control && seq_end))
                done <= 1'b0;

            if (state == S_STROBE && state_nxt == S_WAIT)
                wait_cnt <= p_eff - PERIOD_W'(2);
            else if (state == S_WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - PERIOD_W'(1);
        end
    end

    always_comb begin
        ctl_readdata = '0;
        case (ctl_address)
            4'd0: ctl_readdata[2:0] = {irq_en, loop, run};
            4'd1: ctl_readdata[6:0] = {index, 2'b00, done, busy};
            4'd2: ctl_readdata[PERIOD_W-1:0] = period;
            4'd3: ctl_readdata[2:0] = last;
            default: begin
                if (ctl_address[3]) ctl_readdata[LED_W-1:0] = pattern[ctl_address[2:0]];
            end
        endcase
    end

endmodule
